// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, long-press detection and auto-repeat.
// Every output is registered and each pulse output is exactly one clkdigit cycle wide.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 5,
    parameter int LONG_TICKS     = 120,
    parameter int REPEAT_TICKS   = 24,
    parameter bit REPEAT_EN      = 1'b1
) (
    input  logic clkdigit,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic long_pulse,
    output logic release_pulse
);

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] DEB_MAX     = 8'(DEBOUNCE_TICKS);
    localparam logic [9:0] LONG_MAX    = 10'(LONG_TICKS);
    localparam logic [9:0] REP_MAX     = 10'(REPEAT_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_next;
    logic                   w_s2;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_dcnt;
    logic [7:0] w_dcnt_next;
    logic [7:0] w_dcnt_inc;
    logic [9:0] r_hcnt;
    logic [9:0] w_hcnt_next;
    logic [9:0] w_hcnt_inc;
    logic [9:0] r_rcnt;
    logic [9:0] w_rcnt_next;
    logic [9:0] w_rcnt_inc;
    logic       r_ret;
    logic       w_ret_next;
    logic       r_level;
    logic       w_level_next;
    logic       r_press;
    logic       w_press_next;
    logic       r_long;
    logic       w_long_next;
    logic       r_release;
    logic       w_release_next;

    // Actions shared between states; resolved after the per-state decode.
    logic w_accept_press;
    logic w_start_release;
    logic w_release_ret;
    logic w_accept_release;
    logic w_do_hold;
    logic w_do_repeat;

    assign w_sync_next = {r_sync[SYNC_STAGES-2:0], btn_raw};
    assign w_s2        = r_sync[SYNC_STAGES-1];
    assign w_dcnt_inc  = r_dcnt + 8'd1;
    assign w_hcnt_inc  = r_hcnt + 10'd1;
    assign w_rcnt_inc  = r_rcnt + 10'd1;

    always_ff @(posedge clkdigit) begin
        if (reset) begin
            r_sync    <= '0;
            r_state   <= IDLE;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_rcnt    <= '0;
            r_ret     <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_long    <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= w_sync_next;
            r_state   <= w_state_next;
            r_dcnt    <= w_dcnt_next;
            r_hcnt    <= w_hcnt_next;
            r_rcnt    <= w_rcnt_next;
            r_ret     <= w_ret_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_long    <= w_long_next;
            r_release <= w_release_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_dcnt_next      = r_dcnt;
        w_hcnt_next      = r_hcnt;
        w_rcnt_next      = r_rcnt;
        w_ret_next       = r_ret;
        w_level_next     = r_level;
        w_press_next     = 1'b0;
        w_long_next      = 1'b0;
        w_release_next   = 1'b0;
        w_accept_press   = 1'b0;
        w_start_release  = 1'b0;
        w_release_ret    = 1'b0;
        w_accept_release = 1'b0;
        w_do_hold        = 1'b0;
        w_do_repeat      = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_level_next = 1'b0;
                w_dcnt_next  = '0;
                if (w_s2) begin
                    if (DEB_MAX == 8'd1) begin
                        w_accept_press = 1'b1;
                    end else begin
                        w_state_next = PRESS_WAIT;
                        w_dcnt_next  = 8'd1;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!w_s2) begin
                    w_state_next = IDLE;
                    w_dcnt_next  = '0;
                end else if (w_dcnt_inc == DEB_MAX) begin
                    w_accept_press = 1'b1;
                end else begin
                    w_dcnt_next = w_dcnt_inc;
                end
            end
            PRESSED: begin
                if (!w_s2) begin
                    w_start_release = 1'b1;
                    w_release_ret   = 1'b0;
                end else begin
                    w_do_hold = 1'b1;
                end
            end
            REPEAT: begin
                if (!w_s2) begin
                    w_start_release = 1'b1;
                    w_release_ret   = 1'b1;
                end else begin
                    w_do_repeat = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // Returning counts as a held cycle, so only RELEASE_WAIT cycles delay the timers.
                if (w_s2) begin
                    w_dcnt_next = '0;
                    if (r_ret) begin
                        w_do_repeat = 1'b1;
                    end else begin
                        w_do_hold = 1'b1;
                    end
                end else if (w_dcnt_inc == DEB_MAX) begin
                    w_accept_release = 1'b1;
                end else begin
                    w_dcnt_next = w_dcnt_inc;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_accept_press) begin
            w_state_next = PRESSED;
            w_level_next = 1'b1;
            w_press_next = 1'b1;
            w_hcnt_next  = '0;
            w_dcnt_next  = '0;
        end

        if (w_do_hold) begin
            w_state_next = PRESSED;
            if (r_hcnt < LONG_MAX) begin
                w_hcnt_next = w_hcnt_inc;
                if (w_hcnt_inc == LONG_MAX) begin
                    w_long_next = 1'b1;
                    if (REPEAT_EN) begin
                        w_state_next = REPEAT;
                        w_rcnt_next  = '0;
                    end
                end
            end
        end

        if (w_do_repeat) begin
            w_state_next = REPEAT;
            if (w_rcnt_inc == REP_MAX) begin
                w_press_next = 1'b1;
                w_rcnt_next  = '0;
            end else begin
                w_rcnt_next = w_rcnt_inc;
            end
        end

        // A release sample wins over any long/repeat pulse due this cycle.
        if (w_start_release) begin
            w_ret_next = w_release_ret;
            if (DEB_MAX == 8'd1) begin
                w_accept_release = 1'b1;
            end else begin
                w_state_next = RELEASE_WAIT;
                w_dcnt_next  = 8'd1;
            end
        end

        if (w_accept_release) begin
            w_state_next   = IDLE;
            w_level_next   = 1'b0;
            w_release_next = 1'b1;
            w_dcnt_next    = '0;
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign long_pulse    = r_long;
    assign release_pulse = r_release;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: expected pulse events are queued per scenario and
// matched in order against the pulses the selected DUT instance produces.
module tb_btn_debounce;

    logic clk;
    logic reset;
    logic btn_raw;

    logic lvl0, press0, long0, rel0;
    logic lvl1, press1, long1, rel1;
    logic lvl2, press2, long2, rel2;

    int checks;
    int failures;

    typedef struct {
        int kind;
        int edge_n;
    } ev_t;

    ev_t sb_q[$];
    bit  pat[0:299];
    bit  exp_lvl[0:299];

    btn_debounce u_dut (
        .clkdigit     (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (lvl0),
        .press_pulse  (press0),
        .long_pulse   (long0),
        .release_pulse(rel0)
    );

    btn_debounce #(.REPEAT_EN(1'b0)) u_dut_norep (
        .clkdigit     (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (lvl1),
        .press_pulse  (press1),
        .long_pulse   (long1),
        .release_pulse(rel1)
    );

    btn_debounce #(
        .DEBOUNCE_TICKS(1),
        .LONG_TICKS    (2),
        .REPEAT_TICKS  (2),
        .REPEAT_EN     (1'b1)
    ) u_dut_fast (
        .clkdigit     (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (lvl2),
        .press_pulse  (press2),
        .long_pulse   (long2),
        .release_pulse(rel2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {level, release, long, press}
    function automatic logic [3:0] get_obs(input int sel);
        case (sel)
            1:       return {lvl1, rel1, long1, press1};
            2:       return {lvl2, rel2, long2, press2};
            default: return {lvl0, rel0, long0, press0};
        endcase
    endfunction

    task automatic clear_pattern();
        for (int i = 0; i < 300; i++) begin
            pat[i]     = 1'b0;
            exp_lvl[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    task automatic set_raw(input int lo, input int hi, input bit val);
        for (int i = lo; i <= hi; i++) pat[i] = val;
    endtask

    task automatic set_level(input int on_edge, input int off_edge);
        for (int i = on_edge; i < off_edge; i++) exp_lvl[i] = 1'b1;
    endtask

    task automatic push_ev(input int kind, input int edge_n);
        ev_t e;
        e.kind   = kind;
        e.edge_n = edge_n;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        btn_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives pat[] on edges 0..n-1 and checks pulses against the queue and level against exp_lvl[].
    task automatic run(input string name, input int sel, input int n);
        logic [3:0] o;
        ev_t        e;
        int         npulse;
        for (int ed = 0; ed < n; ed++) begin
            btn_raw = pat[ed];
            @(posedge clk);
            #1;
            o      = get_obs(sel);
            npulse = int'(o[0]) + int'(o[1]) + int'(o[2]);
            checks++;
            if (npulse > 1) begin
                failures++;
                $display("FAIL %s exclusive: edge=%0d got pulses=%b, required at most one", name, ed, o[2:0]);
            end
            for (int k = 0; k < 3; k++) begin
                if (o[k]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s pulse: got kind=%0d at edge=%0d, required no pulse", name, k, ed);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.kind !== k || e.edge_n !== ed) begin
                            failures++;
                            $display("FAIL %s pulse: got kind=%0d edge=%0d, required kind=%0d edge=%0d",
                                     name, k, ed, e.kind, e.edge_n);
                        end else begin
                            $display("%s: pulse kind=%0d at edge=%0d ok", name, k, ed);
                        end
                    end
                end
            end
            checks++;
            if (o[3] !== exp_lvl[ed]) begin
                failures++;
                $display("FAIL %s level: edge=%0d got btn_level=%b, required %b", name, ed, o[3], exp_lvl[ed]);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            e = sb_q[0];
            $display("FAIL %s missing: got %0d unmatched events, required 0 (first kind=%0d edge=%0d)",
                     name, sb_q.size(), e.kind, e.edge_n);
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        logic [3:0] o;
        btn_raw = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            o = get_obs(0);
            checks++;
            if (o !== 4'b0000) begin
                failures++;
                $display("FAIL reset outputs: cycle=%0d got %b, required 0000", i, o);
            end
        end
        reset = 1'b0;
        clear_pattern();
        set_raw(0, 19, 1'b1);
        set_level(6, 26);
        push_ev(0, 6);
        push_ev(2, 26);
        run("reset", 0, 35);
    endtask

    task automatic test_clean_press();
        do_reset();
        clear_pattern();
        set_raw(0, 19, 1'b1);
        set_level(6, 26);
        push_ev(0, 6);
        push_ev(2, 26);
        run("clean_press", 0, 35);
    endtask

    task automatic test_bounce();
        bit [6:0] seq;
        do_reset();
        clear_pattern();
        seq = 7'b0110111;
        for (int i = 0; i < 7; i++) pat[i] = seq[i];
        set_raw(7, 29, 1'b1);
        set_level(13, 36);
        push_ev(0, 13);
        push_ev(2, 36);
        run("bounce", 0, 45);
    endtask

    task automatic test_long_repeat();
        do_reset();
        clear_pattern();
        set_raw(0, 205, 1'b1);
        set_level(6, 212);
        push_ev(0, 6);
        push_ev(1, 126);
        push_ev(0, 150);
        push_ev(0, 174);
        push_ev(0, 198);
        push_ev(2, 212);
        run("long_repeat", 0, 225);
    endtask

    task automatic test_release_glitch();
        do_reset();
        clear_pattern();
        set_raw(0, 205, 1'b1);
        set_raw(50, 51, 1'b0);
        set_level(6, 212);
        push_ev(0, 6);
        push_ev(1, 128);
        push_ev(0, 152);
        push_ev(0, 176);
        push_ev(0, 200);
        push_ev(2, 212);
        run("release_glitch", 0, 225);
    endtask

    task automatic test_no_repeat();
        do_reset();
        clear_pattern();
        set_raw(0, 205, 1'b1);
        set_level(6, 212);
        push_ev(0, 6);
        push_ev(1, 126);
        push_ev(2, 212);
        run("no_repeat", 1, 225);
    endtask

    task automatic test_fast_boundary();
        do_reset();
        clear_pattern();
        set_raw(0, 9, 1'b1);
        set_level(2, 12);
        push_ev(0, 2);
        push_ev(1, 4);
        push_ev(0, 6);
        push_ev(0, 8);
        push_ev(0, 10);
        push_ev(2, 12);
        run("fast_boundary", 2, 20);
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_pattern();
        set_raw(0, 9, 1'b1);
        set_raw(16, 25, 1'b1);
        set_level(6, 16);
        set_level(22, 32);
        push_ev(0, 6);
        push_ev(2, 16);
        push_ev(0, 22);
        push_ev(2, 32);
        run("back_to_back", 0, 40);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        btn_raw  = 1'b0;
        do_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_glitch();
        test_no_repeat();
        test_fast_boundary();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and conditions a raw push-button input, producing clean single-cycle press, long-press and release events plus auto-repeat. It sits directly upstream of the two-digit FND button counter: `press_pulse` drives that counter's `btn` input, and each pulse advances the count by one. The block runs on the 240 Hz digit-scan clock `clkdigit`, so one cycle is about 4.17 ms. At that rate the debounce window fits in a handful of ticks and every output pulse is wide enough to be seen by the consumer.

## Interface
- `DEBOUNCE_TICKS`, default 5: consecutive stable samples needed to accept a level change (≈20.8 ms). Legal range 1..255.
- `LONG_TICKS`, default 120: cycles in the pressed state before `long_pulse` fires (0.5 s). Legal range 2..1023.
- `REPEAT_TICKS`, default 24: auto-repeat period (100 ms). Legal range 2..1023.
- `REPEAT_EN`, default 1: 1 enables auto-repeat after a long press.

Ports:
- `clkdigit`, in, 1: block clock (240 Hz scan clock).
- `reset`, in, 1: reset, synchronous, active-high.
- `btn_raw`, in, 1: asynchronous, bouncy button level, active-high.
- `btn_level`, out, 1: debounced button level.
- `press_pulse`, out, 1: one-cycle pulse on an accepted press and on each auto-repeat.
- `long_pulse`, out, 1: one-cycle pulse when the long-press threshold is reached.
- `release_pulse`, out, 1: one-cycle pulse on an accepted release.

## Operation
- **Synchroniser:** a 2-flop synchroniser, `s1 <= btn_raw` and `s2 <= s1`. The FSM uses only `s2`.
- **Reset:** state IDLE. `s1`, `s2`, all counters, the return flag and all outputs are 0.
- **Counters:**
  - 8-bit debounce counter `dcnt`.
  - 10-bit hold counter `hcnt`.
  - 10-bit repeat counter `rcnt`.
  - 1-bit return flag `ret`.
- **IDLE** (`btn_level` = 0): if `s2`=1, go to PRESS_WAIT with `dcnt`=1. If `DEBOUNCE_TICKS`=1, go directly to PRESSED.
- **PRESS_WAIT:**
  - If `s2`=0, go to IDLE with `dcnt`=0 (bounce rejected, no output).
  - If `s2`=1, increment `dcnt`. When it reaches `DEBOUNCE_TICKS`, go to PRESSED with `btn_level`←1, `press_pulse`←1 and `hcnt`←0.
- **PRESSED:**
  - If `s2`=0, go to RELEASE_WAIT with `dcnt`=1 and `ret`=0.
  - Otherwise increment `hcnt` while it is below `LONG_TICKS`.
  - When `hcnt` reaches `LONG_TICKS`, assert `long_pulse` for one cycle.
    - If `REPEAT_EN`=1, go to REPEAT with `rcnt`←0.
    - If `REPEAT_EN`=0, stay in PRESSED with `hcnt` saturated; no further pulses.
- **REPEAT:**
  - If `s2`=0, go to RELEASE_WAIT with `dcnt`=1 and `ret`=1.
  - Otherwise increment `rcnt`. When it reaches `REPEAT_TICKS`, assert `press_pulse` for one cycle and set `rcnt`←0.
- **RELEASE_WAIT** (`btn_level` stays 1; `hcnt` and `rcnt` frozen):
  - If `s2`=1, return to PRESSED (`ret`=0) or REPEAT (`ret`=1), counters resuming from their frozen values.
  - If `s2`=0, increment `dcnt`. When it reaches `DEBOUNCE_TICKS`, go to IDLE with `btn_level`←0 and `release_pulse`←1.
- **Simultaneous events:** a release sample (`s2`=0) takes priority over a `long_pulse` or repeat `press_pulse` falling in the same cycle; that pulse is not emitted. At most one of the three pulse outputs is high in any cycle.
- **Reset mid-operation:** all state is discarded. A button still held after reset must pass a fresh debounce and produces a new `press_pulse`.

## Timing
- All outputs are registered.
- **Press latency:** edge 0 is the first `clkdigit` edge that samples `btn_raw`=1 into `s1`. `press_pulse` and `btn_level` go high after edge `DEBOUNCE_TICKS`+1 (edge 6 at default).
- **Release latency:** measured the same way from the first edge sampling 0, `release_pulse` goes high and `btn_level` goes low after edge `DEBOUNCE_TICKS`+1.
- **Long press:** with P the press edge, `long_pulse` fires at edge P+`LONG_TICKS`, plus any cycles spent in RELEASE_WAIT.
- **Auto-repeat:** repeat `press_pulse` edges fall at P+`LONG_TICKS`+k·`REPEAT_TICKS`, for k ≥ 1.
- **Pulse shape:** every pulse is exactly 1 cycle wide. Consecutive `press_pulse`s are separated by at least `REPEAT_TICKS`−1 low cycles, which is ≥ 1 at the minimum `REPEAT_TICKS`=2.

## Test plan
1. **Reset:** assert `reset` for 3 cycles with `btn_raw`=1 → all outputs are 0 during reset and the cycle after it. `press_pulse` then fires 7 edges after the edge at which `reset` is deasserted.
2. **Clean press:** `btn_raw`=1 on edges 0..19, then 0 → `press_pulse` high only after edge 6, `btn_level` high after edges 6..25, `release_pulse` high only after edge 26. There is no `long_pulse`.
3. **Bounce:** `btn_raw` sequence 1,1,1,0,1,1,0 on edges 0..6, then solid 1 from edge 7 → no output until `press_pulse` after edge 13. Exactly one `press_pulse` is produced.
4. **Long hold with repeat, default parameters:** `btn_raw`=1 on edges 0..205 →
   - `press_pulse` after edges 6, 150, 174 and 198;
   - `long_pulse` after edge 126;
   - `release_pulse` after edge 212.
5. **Release glitch:** holding from the test-4 stimulus, `btn_raw`=0 on edges 50..51 only → no `release_pulse`, `btn_level` stays 1, `long_pulse` is delayed 2 cycles to edge 128.
6. **`REPEAT_EN`=0 with the test-4 stimulus** → one `press_pulse` after edge 6, `long_pulse` after edge 126, no further `press_pulse`, `release_pulse` after edge 212.
